// File: rtl/ex_div_iter.sv
// Iterative radix-2 restoring divider (DIV/DIVU) for the EX stage; quotient -> LO, remainder -> HI.
// Latency: operands accepted at edge E, out_valid high from edge E+WIDTH; one division in flight.
// Backpressure: result held stable in DONE until out_ready; in_ready stays low until the result is taken.
module ex_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  input  logic             cancel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quot,
  output logic [WIDTH-1:0] out_rem
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [2*WIDTH-1:0] r_pr;        // {partial remainder, dividend bits / quotient bits}
  logic [WIDTH-1:0]   r_dvsr;      // |divisor|
  logic               r_quot_neg;
  logic               r_rem_neg;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_rem;

  logic               w_accept;
  logic [WIDTH-1:0]   w_dvd_abs;
  logic [WIDTH-1:0]   w_dvs_abs;
  logic [WIDTH:0]     w_upper;     // upper WIDTH+1 bits of the left-shifted partial remainder
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic [2*WIDTH-1:0] w_pr_next;
  logic [WIDTH-1:0]   w_q_mag;
  logic [WIDTH-1:0]   w_r_mag;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;

  assign w_accept = in_valid && r_in_ready;

  // Operand magnitudes; DIVU passes operands through untouched.
  // The WIDTH-bit negation of the most negative value wraps to itself, which the
  // unsigned iteration then treats as 2^(WIDTH-1), giving the intended overflow result.
  assign w_dvd_abs = (in_signed && in_dividend[WIDTH-1]) ? ({WIDTH{1'b0}} - in_dividend) : in_dividend;
  assign w_dvs_abs = (in_signed && in_divisor[WIDTH-1])  ? ({WIDTH{1'b0}} - in_divisor)  : in_divisor;

  // One restoring step: shift left by one, trial-subtract |divisor| from the top WIDTH+1 bits.
  // When the trial succeeds the true difference is below |divisor|, so its low WIDTH bits are exact.
  // A zero divisor always succeeds, yielding an all-ones quotient and remainder = |dividend|.
  assign w_upper   = r_pr[2*WIDTH-1:WIDTH-1];
  assign w_ge      = (w_upper >= {1'b0, r_dvsr});
  assign w_diff    = w_upper[WIDTH-1:0] - r_dvsr;
  assign w_pr_next = w_ge ? {w_diff, r_pr[WIDTH-2:0], 1'b1}
                          : {w_upper[WIDTH-1:0], r_pr[WIDTH-2:0], 1'b0};

  // Sign correction applied to the final iteration's result; remainder follows the dividend sign.
  assign w_q_mag = w_pr_next[WIDTH-1:0];
  assign w_r_mag = w_pr_next[2*WIDTH-1:WIDTH];
  assign w_q_fix = r_quot_neg ? ({WIDTH{1'b0}} - w_q_mag) : w_q_mag;
  assign w_r_fix = r_rem_neg  ? ({WIDTH{1'b0}} - w_r_mag) : w_r_mag;

  // Control FSM and datapath: accept, iterate WIDTH times, hold the result until consumed.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_pr        <= '0;
      r_dvsr      <= '0;
      r_quot_neg  <= 1'b0;
      r_rem_neg   <= 1'b0;
      r_count     <= '0;
      r_quot      <= '0;
      r_rem       <= '0;
    end else if (cancel) begin
      // Flush wins over accept, iteration and handshake; results keep their last value.
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_count     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_pr        <= {{WIDTH{1'b0}}, w_dvd_abs};
            r_dvsr      <= w_dvs_abs;
            r_quot_neg  <= in_signed && (in_dividend[WIDTH-1] ^ in_divisor[WIDTH-1]);
            r_rem_neg   <= in_signed && in_dividend[WIDTH-1];
            r_count     <= '0;
            r_in_ready  <= 1'b0;
            r_state     <= S_CALC;
          end
        end
        S_CALC: begin
          r_pr    <= w_pr_next;
          r_count <= r_count + 1'b1;
          if (r_count == LAST_ITER) begin
            r_quot      <= w_q_fix;
            r_rem       <= w_r_fix;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_quot  = r_quot;
  assign out_rem   = r_rem;

endmodule

// File: tb/tb_ex_div_iter.sv
// Self-checking bench for ex_div_iter: directed MIPS corner cases, backpressure,
// cancel, mid-operation reset and randomized back-to-back divisions against a
// plain-arithmetic reference model.
module tb_ex_div_iter;

  localparam int W = 32;

  logic         clk;
  logic         resetn;
  logic         in_valid;
  logic         in_ready;
  logic         in_signed;
  logic [W-1:0] in_dividend;
  logic [W-1:0] in_divisor;
  logic         cancel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_quot;
  logic [W-1:0] out_rem;

  int n_checks = 0;
  int n_fail   = 0;

  ex_div_iter #(.WIDTH(W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_signed  (in_signed),
    .in_dividend(in_dividend),
    .in_divisor (in_divisor),
    .cancel     (cancel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_quot   (out_quot),
    .out_rem    (out_rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: MIPS semantics from plain 64-bit arithmetic (truncating division,
  // remainder sign follows the dividend); divide-by-zero gives |q| = all ones, r = dividend.
  function automatic void ref_div(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa;
    longint sb;
    if (b == 0) begin
      q = (s && a[W-1]) ? 32'd1 : 32'hFFFF_FFFF;
      r = a;
    end else begin
      sa = s ? longint'($signed(a)) : longint'(a);
      sb = s ? longint'($signed(b)) : longint'(b);
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end
  endfunction

  // Drives one operand pair, waits for the result with out_ready high, consumes it.
  // lat = edges after the accept edge until out_valid is first observed (-1 on timeout).
  task automatic run_div(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output int lat);
    int n;
    @(negedge clk);
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    in_valid    = 1'b1;
    in_signed   = s;
    in_dividend = a;
    in_divisor  = b;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    in_signed   = $urandom_range(0, 1);
    in_dividend = $urandom;
    in_divisor  = $urandom;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    q = out_quot;
    r = out_rem;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; in_valid = 1'b0; in_signed = 1'b0; in_dividend = '0;
    in_divisor = '0; cancel = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (out_quot !== '0) begin n_fail++; $display("FAIL reset_out_quot got=%h exp=0", out_quot); end
    n_checks++; if (out_rem !== '0) begin n_fail++; $display("FAIL reset_out_rem got=%h exp=0", out_rem); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_directed();
    bit           vs [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] va [6] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd5, 32'd7};
    logic [W-1:0] vb [6] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [W-1:0] eq [6] = '{32'h0000_000E, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [W-1:0] er [6] = '{32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0000_0005, 32'h0000_0007};
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           lat;
    for (int i = 0; i < 6; i++) begin
      run_div(vs[i], va[i], vb[i], q, r, lat);
      n_checks++; if (q !== eq[i]) begin n_fail++; $display("FAIL directed_quot[%0d] got=%h exp=%h", i, q, eq[i]); end
      n_checks++; if (r !== er[i]) begin n_fail++; $display("FAIL directed_rem[%0d] got=%h exp=%h", i, r, er[i]); end
      n_checks++; if (lat !== W) begin n_fail++; $display("FAIL directed_latency[%0d] got=%0d exp=%0d", i, lat, W); end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic [W-1:0] qs;
    logic [W-1:0] rs;
    int           n;
    ref_div(1'b0, 32'd1000, 32'd9, eq, er);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_signed = 1'b0;
    in_dividend = 32'd1000; in_divisor = 32'd9;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_busy_in_ready got=%b exp=0", in_ready); end
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_checks++; if (n !== W) begin n_fail++; $display("FAIL bp_latency got=%0d exp=%0d", n, W); end
    qs = out_quot;
    rs = out_rem;
    n_checks++; if (qs !== eq) begin n_fail++; $display("FAIL bp_quot got=%h exp=%h", qs, eq); end
    n_checks++; if (rs !== er) begin n_fail++; $display("FAIL bp_rem got=%h exp=%h", rs, er); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d] got=%b exp=1", i, out_valid); end
      n_checks++; if (out_quot !== eq) begin n_fail++; $display("FAIL bp_hold_quot[%0d] got=%h exp=%h", i, out_quot, eq); end
      n_checks++; if (out_rem !== er) begin n_fail++; $display("FAIL bp_hold_rem[%0d] got=%h exp=%h", i, out_rem, er); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_in_ready[%0d] got=%b exp=0", i, in_ready); end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_cancel();
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           lat;
    bit           seen;
    // cancel with in_valid in IDLE: no accept may happen
    @(negedge clk);
    in_valid = 1'b1; cancel = 1'b1; in_signed = 1'b0; in_dividend = 32'd50; in_divisor = 32'd5;
    @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL cancel_idle_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    cancel = 1'b0; in_valid = 1'b0;
    // accept 100/7, cancel at iteration 10
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_dividend = 32'd100; in_divisor = 32'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL cancel_calc_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL cancel_calc_out_valid got=%b exp=0", out_valid); end
    @(negedge clk);
    cancel = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      seen |= out_valid;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL cancel_no_result got=%b exp=0", seen); end
    run_div(1'b0, 32'd9, 32'd3, q, r, lat);
    n_checks++; if (q !== 32'd3) begin n_fail++; $display("FAIL cancel_after_quot got=%h exp=3", q); end
    n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL cancel_after_rem got=%h exp=0", r); end
    n_checks++; if (lat !== W) begin n_fail++; $display("FAIL cancel_after_latency got=%0d exp=%0d", lat, W); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1; in_signed = 1'b1; in_dividend = 32'hFFFF_FF00; in_divisor = 32'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (out_quot !== '0) begin n_fail++; $display("FAIL rstmid_out_quot got=%h exp=0", out_quot); end
    n_checks++; if (out_rem !== '0) begin n_fail++; $display("FAIL rstmid_out_rem got=%h exp=0", out_rem); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_back_to_back();
    bit           s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    int           lat;
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        3:       b = a;
        4:       b = 32'd1;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      ref_div(s, a, b, eq, er);
      run_div(s, a, b, q, r, lat);
      n_checks++; if (q !== eq) begin n_fail++; $display("FAIL rand_quot[%0d] s=%0d a=%h b=%h got=%h exp=%h", i, s, a, b, q, eq); end
      n_checks++; if (r !== er) begin n_fail++; $display("FAIL rand_rem[%0d] s=%0d a=%h b=%h got=%h exp=%h", i, s, a, b, r, er); end
      n_checks++; if (lat !== W) begin n_fail++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", i, lat, W); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_cancel();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
